// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor.
// Holds the machine interrupt-enable/pending CSRs, a prescaled 64-bit
// mtime/mtimecmp timer, and NUM_LOCAL platform interrupt lines (each level or
// rising-edge latched). It folds pending interrupts and synchronous
// exceptions into one trap request plus a registered mcause value.
module clint_timer #(
  parameter int unsigned          NUM_LOCAL = 4,
  parameter logic [NUM_LOCAL-1:0] EDGE_MASK = '0,
  parameter int unsigned          PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 csr_write,
  input  logic [1:0]           csr_op,
  input  logic [11:0]          csr_addr,
  input  logic [31:0]          csr_wr_data,
  output logic [31:0]          csr_rd_data,
  input  logic                 interrupts_enabled,
  input  logic                 ext_irq,
  input  logic [NUM_LOCAL-1:0] local_irq,
  input  logic                 illegal_inst,
  input  logic                 inst_addr_misalign,
  input  logic                 load_addr_misalign,
  input  logic                 store_addr_misalign,
  input  logic                 env_call,
  input  logic                 env_break,
  output logic                 trap_pending,
  output logic [31:0]          trap_cause
);

  localparam logic [1:0]  CSR_OP_WRITE = 2'b01;
  localparam logic [1:0]  CSR_OP_SET   = 2'b10;
  localparam logic [1:0]  CSR_OP_CLEAR = 2'b11;

  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MTIME_LO = 12'h7C0;
  localparam logic [11:0] ADDR_MTIME_HI = 12'h7C1;
  localparam logic [11:0] ADDR_CMP_LO   = 12'h7C2;
  localparam logic [11:0] ADDR_CMP_HI   = 12'h7C3;

  localparam logic [30:0] CODE_INST_MISALIGN  = 31'd0;
  localparam logic [30:0] CODE_ILLEGAL        = 31'd2;
  localparam logic [30:0] CODE_BREAK          = 31'd3;
  localparam logic [30:0] CODE_LOAD_MISALIGN  = 31'd4;
  localparam logic [30:0] CODE_STORE_MISALIGN = 31'd6;
  localparam logic [30:0] CODE_ECALL          = 31'd11;
  localparam logic [30:0] CODE_MSI            = 31'd3;
  localparam logic [30:0] CODE_MTI            = 31'd7;
  localparam logic [30:0] CODE_MEI            = 31'd11;
  localparam logic [30:0] CODE_LOCAL_BASE     = 31'd16;
  localparam logic [31:0] HARDWARE_ERROR      = 32'd19;

  // Local lines occupy mip/mie bits [16 +: NUM_LOCAL].
  localparam logic [31:0] LOCAL_BITS = 32'((33'd1 << NUM_LOCAL) - 33'd1) << 5'd16;
  localparam logic [31:0] EDGE_BITS  = 32'(EDGE_MASK) << 5'd16;
  localparam logic [31:0] LEVEL_BITS = LOCAL_BITS & ~EDGE_BITS;
  localparam logic [31:0] MIE_BITS   = LOCAL_BITS | 32'h0000_0888;
  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [31:0]          mie_r, mip_r, trap_cause_r;
  logic [63:0]          mtime_r, mtimecmp_r;
  logic [15:0]          presc_r;
  logic [NUM_LOCAL-1:0] sample_r, history_r;

  logic [31:0] csr_rd_s, wr_val_s, mip_nxt_s, edge_keep_s, edge_rise_s, local_wide_s, pend_s;
  logic [63:0] mtime_nxt_s;
  logic [15:0] presc_nxt_s;
  logic        wr_en_s, mie_we_s, mip_we_s, mtime_lo_we_s, mtime_hi_we_s, cmp_lo_we_s, cmp_hi_we_s;
  logic        irq_pend_s, exc_any_s;
  logic [30:0] local_code_s, cause_code_s;

  // Combinational read of the addressed CSR; unmapped addresses read zero.
  always_comb begin
    csr_rd_s = 32'h0000_0000;
    case (csr_addr)
      ADDR_MIE:      csr_rd_s = mie_r;
      ADDR_MIP:      csr_rd_s = mip_r;
      ADDR_MTIME_LO: csr_rd_s = mtime_r[31:0];
      ADDR_MTIME_HI: csr_rd_s = mtime_r[63:32];
      ADDR_CMP_LO:   csr_rd_s = mtimecmp_r[31:0];
      ADDR_CMP_HI:   csr_rd_s = mtimecmp_r[63:32];
      default:       csr_rd_s = 32'h0000_0000;
    endcase
  end

  assign csr_rd_data = csr_rd_s;

  // Form the value to write from the operation; unknown ops update nothing.
  always_comb begin
    wr_val_s = csr_rd_s;
    wr_en_s  = 1'b0;
    case (csr_op)
      CSR_OP_WRITE: begin wr_val_s = csr_wr_data;              wr_en_s = csr_write; end
      CSR_OP_SET:   begin wr_val_s = csr_rd_s | csr_wr_data;   wr_en_s = csr_write; end
      CSR_OP_CLEAR: begin wr_val_s = csr_rd_s & ~csr_wr_data;  wr_en_s = csr_write; end
      default:      begin wr_val_s = csr_rd_s;                 wr_en_s = 1'b0;      end
    endcase
  end

  assign mie_we_s      = wr_en_s && (csr_addr == ADDR_MIE);
  assign mip_we_s      = wr_en_s && (csr_addr == ADDR_MIP);
  assign mtime_lo_we_s = wr_en_s && (csr_addr == ADDR_MTIME_LO);
  assign mtime_hi_we_s = wr_en_s && (csr_addr == ADDR_MTIME_HI);
  assign cmp_lo_we_s   = wr_en_s && (csr_addr == ADDR_CMP_LO);
  assign cmp_hi_we_s   = wr_en_s && (csr_addr == ADDR_CMP_HI);

  assign local_wide_s = 32'(local_irq) << 5'd16;
  assign edge_rise_s  = (32'(sample_r & ~history_r) << 5'd16) & EDGE_BITS;

  // Next mip: hardware-sourced bits resample every cycle, MSIP follows CSR
  // writes, latched edge bits only clear on a write and a new edge wins.
  always_comb begin
    mip_nxt_s     = 32'h0000_0000;
    edge_keep_s   = 32'h0000_0000;
    mip_nxt_s[11] = ext_irq;
    mip_nxt_s[7]  = (mtime_r >= mtimecmp_r);
    if (mip_we_s) begin
      mip_nxt_s[3] = wr_val_s[3];
      edge_keep_s  = mip_r & wr_val_s & EDGE_BITS;
    end else begin
      mip_nxt_s[3] = mip_r[3];
      edge_keep_s  = mip_r & EDGE_BITS;
    end
    mip_nxt_s = mip_nxt_s | edge_keep_s | edge_rise_s | (local_wide_s & LEVEL_BITS);
  end

  // Timer advance: a write to either half takes over the cycle and restarts
  // the prescaler; otherwise mtime steps when the prescaler completes.
  always_comb begin
    mtime_nxt_s = mtime_r;
    presc_nxt_s = presc_r;
    if (mtime_lo_we_s || mtime_hi_we_s) begin
      presc_nxt_s = 16'd0;
      if (mtime_lo_we_s) begin
        mtime_nxt_s[31:0] = wr_val_s;
      end else begin
        mtime_nxt_s[63:32] = wr_val_s;
      end
    end else if (presc_r == PRESCALE_LAST) begin
      presc_nxt_s = 16'd0;
      mtime_nxt_s = mtime_r + 64'd1;
    end else begin
      presc_nxt_s = presc_r + 16'd1;
    end
  end

  assign pend_s       = mip_r & mie_r;
  assign irq_pend_s   = (|pend_s) & interrupts_enabled;
  assign exc_any_s    = illegal_inst | inst_addr_misalign | load_addr_misalign |
                        store_addr_misalign | env_call | env_break;
  assign trap_pending = irq_pend_s | exc_any_s;

  // Lowest-index pending local line; scanned high-to-low so the lowest wins.
  always_comb begin
    local_code_s = CODE_LOCAL_BASE;
    for (int i = NUM_LOCAL - 1; i >= 0; i--) begin
      if (pend_s[16 + i]) begin
        local_code_s = CODE_LOCAL_BASE + 31'(i);
      end else begin
        local_code_s = local_code_s;
      end
    end
  end

  // Cause code: interrupts outrank exceptions, each with a fixed order.
  always_comb begin
    cause_code_s = 31'd0;
    if (irq_pend_s) begin
      if (pend_s[11])     cause_code_s = CODE_MEI;
      else if (pend_s[7]) cause_code_s = CODE_MTI;
      else if (pend_s[3]) cause_code_s = CODE_MSI;
      else                cause_code_s = local_code_s;
    end else begin
      if (illegal_inst)             cause_code_s = CODE_ILLEGAL;
      else if (inst_addr_misalign)  cause_code_s = CODE_INST_MISALIGN;
      else if (env_call)            cause_code_s = CODE_ECALL;
      else if (env_break)           cause_code_s = CODE_BREAK;
      else if (load_addr_misalign)  cause_code_s = CODE_LOAD_MISALIGN;
      else if (store_addr_misalign) cause_code_s = CODE_STORE_MISALIGN;
      else                          cause_code_s = 31'd0;
    end
  end

  // Interrupt CSR state and local-line sampling history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_r     <= 32'h0000_0000;
      mip_r     <= 32'h0000_0000;
      sample_r  <= '0;
      history_r <= '0;
    end else begin
      mie_r     <= mie_we_s ? (wr_val_s & MIE_BITS) : mie_r;
      mip_r     <= mip_nxt_s;
      sample_r  <= local_irq;
      history_r <= sample_r;
    end
  end

  // Timer, compare and prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_r    <= 64'h0000_0000_0000_0000;
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_r    <= 16'd0;
    end else begin
      mtime_r <= mtime_nxt_s;
      presc_r <= presc_nxt_s;
      mtimecmp_r[31:0]  <= cmp_lo_we_s ? wr_val_s : mtimecmp_r[31:0];
      mtimecmp_r[63:32] <= cmp_hi_we_s ? wr_val_s : mtimecmp_r[63:32];
    end
  end

  // Capture the cause whenever a trap is requested; hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_cause_r <= HARDWARE_ERROR;
    end else begin
      trap_cause_r <= trap_pending ? {irq_pend_s, cause_code_s} : trap_cause_r;
    end
  end

  assign trap_cause = trap_cause_r;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed vector table, hand-written
// corner sequences and a randomized run against a cycle-level reference model.
`timescale 1ns/1ps
module tb_clint_timer;

  localparam logic [1:0]  OP_NONE = 2'b00, OP_WRITE = 2'b01, OP_SET = 2'b10, OP_CLEAR = 2'b11;
  localparam logic [11:0] A_MIE = 12'h304, A_MIP = 12'h344, A_TLO = 12'h7C0, A_THI = 12'h7C1;
  localparam logic [11:0] A_CLO = 12'h7C2, A_CHI = 12'h7C3, A_BAD = 12'h300;
  localparam logic [31:0] HW_ERR = 32'd19;
  localparam int          PRIO [7]     = '{11, 7, 3, 16, 17, 18, 19};
  localparam int          EXC_IDX [6]  = '{0, 1, 4, 5, 2, 3};   // illegal, inst, ecall, ebreak, load, store
  localparam int          EXC_CODE [6] = '{2, 0, 11, 3, 4, 6};
  localparam logic [11:0] ADDRS [7]    = '{A_MIE, A_MIP, A_TLO, A_THI, A_CLO, A_CHI, A_BAD};

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        csr_write, interrupts_enabled, ext_irq, trap_pending;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wr_data, csr_rd_data, trap_cause;
  logic [3:0]  local_irq;
  logic [5:0]  exc;  // [0]illegal [1]inst mis [2]load mis [3]store mis [4]ecall [5]ebreak

  logic        csr_write3, trap_pending3;
  logic [1:0]  csr_op3;
  logic [11:0] csr_addr3;
  logic [31:0] csr_wr_data3, csr_rd_data3, trap_cause3;

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0] m_mie, m_mip, m_cause;
  logic [63:0] m_time, m_cmp;
  logic [3:0]  hist1, hist2;

  typedef struct {
    logic        we;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [5:0]  exc;
    logic [31:0] exp_rd;
    logic [31:0] exp_cause;
  } vec_t;
  vec_t vt [12];

  clint_timer #(.NUM_LOCAL(4), .EDGE_MASK(4'b0001), .PRESCALE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .csr_write(csr_write), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data), .interrupts_enabled(interrupts_enabled),
    .ext_irq(ext_irq), .local_irq(local_irq), .illegal_inst(exc[0]), .inst_addr_misalign(exc[1]),
    .load_addr_misalign(exc[2]), .store_addr_misalign(exc[3]), .env_call(exc[4]), .env_break(exc[5]),
    .trap_pending(trap_pending), .trap_cause(trap_cause));

  clint_timer #(.NUM_LOCAL(4), .EDGE_MASK(4'b0101), .PRESCALE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .csr_write(csr_write3), .csr_op(csr_op3), .csr_addr(csr_addr3),
    .csr_wr_data(csr_wr_data3), .csr_rd_data(csr_rd_data3), .interrupts_enabled(1'b0),
    .ext_irq(1'b0), .local_irq(4'b0000), .illegal_inst(1'b0), .inst_addr_misalign(1'b0),
    .load_addr_misalign(1'b0), .store_addr_misalign(1'b0), .env_call(1'b0), .env_break(1'b0),
    .trap_pending(trap_pending3), .trap_cause(trap_cause3));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mie = 32'h0; m_mip = 32'h0; m_cause = HW_ERR;
    m_time = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    hist1 = 4'h0; hist2 = 4'h0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      A_MIE:   return m_mie;
      A_MIP:   return m_mip;
      A_TLO:   return m_time[31:0];
      A_THI:   return m_time[63:32];
      A_CLO:   return m_cmp[31:0];
      A_CHI:   return m_cmp[63:32];
      default: return 32'h0;
    endcase
  endfunction

  // Trap decision from the architectural rules: walk the priority lists.
  task automatic model_trap(output logic tp, output logic [31:0] word);
    logic [31:0] pe;
    logic        ip, found;
    int          code;
    pe = m_mip & m_mie;
    ip = (|pe) & interrupts_enabled;
    tp = ip | (|exc);
    code = 0; found = 1'b0;
    if (ip) begin
      for (int k = 0; k < 7; k++)
        if (!found && pe[PRIO[k]]) begin code = PRIO[k]; found = 1'b1; end
    end else begin
      for (int k = 0; k < 6; k++)
        if (!found && exc[EXC_IDX[k]]) begin code = EXC_CODE[k]; found = 1'b1; end
    end
    word = {ip, 31'(code)};
  endtask

  // One clock: compare outputs with the model, then advance both.
  task automatic cyc();
    logic        tp, we, w_mip;
    logic [31:0] word, rd, wv, n_mie, n_mip;
    logic [63:0] n_time, n_cmp;
    #1;
    model_trap(tp, word);
    rd = m_read(csr_addr);
    chk("rd_data", csr_rd_data, rd);
    chk("trap_pending", trap_pending, tp);
    chk("trap_cause", trap_cause, m_cause);
    we = csr_write && (csr_op != OP_NONE);
    case (csr_op)
      OP_WRITE: wv = csr_wr_data;
      OP_SET:   wv = rd | csr_wr_data;
      OP_CLEAR: wv = rd & ~csr_wr_data;
      default:  wv = rd;
    endcase
    w_mip = we && (csr_addr == A_MIP);
    n_mie = (we && csr_addr == A_MIE) ? (wv & 32'h000F_0888) : m_mie;
    n_mip = 32'h0;
    n_mip[11] = ext_irq;
    n_mip[7]  = (m_time >= m_cmp);
    n_mip[3]  = w_mip ? wv[3] : m_mip[3];
    n_mip[16] = (hist1[0] & ~hist2[0]) | (m_mip[16] & ~(w_mip & ~wv[16]));
    n_mip[19:17] = local_irq[3:1];
    if (we && csr_addr == A_TLO)      n_time = {m_time[63:32], wv};
    else if (we && csr_addr == A_THI) n_time = {wv, m_time[31:0]};
    else                              n_time = m_time + 64'd1;
    n_cmp = m_cmp;
    if (we && csr_addr == A_CLO) n_cmp[31:0]  = wv;
    if (we && csr_addr == A_CHI) n_cmp[63:32] = wv;
    @(posedge clk);
    m_mie = n_mie; m_mip = n_mip; m_time = n_time; m_cmp = n_cmp;
    hist2 = hist1; hist1 = local_irq;
    if (tp) m_cause = word;
    @(negedge clk);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_write = 1'b1; csr_addr = a; csr_op = op; csr_wr_data = d;
    cyc();
    csr_write = 1'b0; csr_op = OP_NONE; csr_wr_data = 32'h0;
  endtask

  initial begin
    logic found;
    csr_write = 1'b0; csr_op = OP_NONE; csr_addr = A_TLO; csr_wr_data = 32'h0;
    interrupts_enabled = 1'b0; ext_irq = 1'b0; local_irq = 4'h0; exc = 6'h0;
    csr_write3 = 1'b0; csr_op3 = OP_NONE; csr_addr3 = A_TLO; csr_wr_data3 = 32'h0;
    model_reset();

    vt[0]  = '{1'b1, OP_WRITE, A_MIE, 32'hFFFF_FFFF, 6'b000000, 32'h000F_0888, HW_ERR};
    vt[1]  = '{1'b1, OP_CLEAR, A_MIE, 32'h0000_0800, 6'b000000, 32'h000F_0088, HW_ERR};
    vt[2]  = '{1'b1, OP_SET,   A_MIE, 32'h0000_0003, 6'b000000, 32'h000F_0088, HW_ERR};
    vt[3]  = '{1'b1, OP_NONE,  A_MIE, 32'h0000_0000, 6'b000000, 32'h000F_0088, HW_ERR};
    vt[4]  = '{1'b1, OP_WRITE, A_BAD, 32'h0000_1234, 6'b000000, 32'h0000_0000, HW_ERR};
    vt[5]  = '{1'b1, OP_WRITE, A_MIE, 32'h0000_0000, 6'b100000, 32'h0000_0000, 32'h0000_0003};
    vt[6]  = '{1'b0, OP_NONE,  A_MIE, 32'h0000_0000, 6'b001100, 32'h0000_0000, 32'h0000_0004};
    vt[7]  = '{1'b0, OP_NONE,  A_MIE, 32'h0000_0000, 6'b001000, 32'h0000_0000, 32'h0000_0006};
    vt[8]  = '{1'b0, OP_NONE,  A_MIE, 32'h0000_0000, 6'b110010, 32'h0000_0000, 32'h0000_0000};
    vt[9]  = '{1'b0, OP_NONE,  A_MIE, 32'h0000_0000, 6'b110000, 32'h0000_0000, 32'h0000_000B};
    vt[10] = '{1'b0, OP_NONE,  A_MIE, 32'h0000_0000, 6'b111111, 32'h0000_0000, 32'h0000_0002};
    vt[11] = '{1'b0, OP_NONE,  A_MIE, 32'h0000_0000, 6'b100100, 32'h0000_0000, 32'h0000_0003};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // free-running mtime after reset, quiet trap outputs
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("mtime_count", csr_rd_data, 32'(k));
      chk("quiet_pending", trap_pending, 1'b0);
      chk("reset_cause", trap_cause, HW_ERR);
      cyc();
    end

    // vector table: CSR ops on mie and exception priority
    for (int v = 0; v < 12; v++) begin
      csr_write = vt[v].we; csr_op = vt[v].op; csr_addr = vt[v].addr;
      csr_wr_data = vt[v].wd; exc = vt[v].exc;
      cyc();
      csr_write = 1'b0; csr_op = OP_NONE; exc = 6'h0;
      #1;
      chk($sformatf("vec%0d_rd", v), csr_rd_data, vt[v].exp_rd);
      chk($sformatf("vec%0d_cause", v), trap_cause, vt[v].exp_cause);
      cyc();
    end

    // timer compare interrupt
    csr_wr(A_CHI, OP_WRITE, 32'h0);
    csr_wr(A_CLO, OP_WRITE, 32'd10);
    csr_wr(A_TLO, OP_WRITE, 32'h0);
    interrupts_enabled = 1'b1;
    csr_wr(A_MIE, OP_SET, 32'h0000_0080);
    csr_addr = A_TLO;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      #1;
      if (csr_rd_data == 32'd10) found = 1'b1;
      else cyc();
    end
    chk("mtime_reached_10", found, 1'b1);
    chk("mti_not_yet", trap_pending, 1'b0);
    cyc();
    #1;
    chk("mti_pending", trap_pending, 1'b1);
    csr_addr = A_MIP;
    #1;
    chk("mtip_bit", csr_rd_data[7], 1'b1);
    cyc();
    #1;
    chk("mti_cause", trap_cause, 32'h8000_0007);
    interrupts_enabled = 1'b0;
    csr_wr(A_MIE, OP_CLEAR, 32'h0000_0080);
    csr_wr(A_CLO, OP_WRITE, 32'hFFFF_FFFF);
    csr_wr(A_CHI, OP_WRITE, 32'hFFFF_FFFF);

    // edge-latched local line 0
    csr_addr = A_MIP;
    local_irq = 4'b0001;
    cyc();
    local_irq = 4'b0000;
    #1;
    chk("edge_one_cycle", csr_rd_data[16], 1'b0);
    cyc();
    #1;
    chk("edge_two_cycles", csr_rd_data[16], 1'b1);
    repeat (2) cyc();
    #1;
    chk("edge_held", csr_rd_data[16], 1'b1);
    csr_wr(A_MIP, OP_CLEAR, 32'h0001_0000);
    #1;
    chk("edge_cleared", csr_rd_data[16], 1'b0);
    local_irq = 4'b0001;
    cyc();
    local_irq = 4'b0000;
    csr_wr(A_MIP, OP_CLEAR, 32'h0001_0000);
    #1;
    chk("edge_set_wins", csr_rd_data[16], 1'b1);
    csr_wr(A_MIP, OP_CLEAR, 32'h0001_0000);

    // interrupt priority MEI > MSI > local
    csr_wr(A_MIE, OP_WRITE, 32'h0002_0808);
    interrupts_enabled = 1'b1; ext_irq = 1'b1; local_irq = 4'b0010;
    csr_wr(A_MIP, OP_SET, 32'h0000_0008);
    repeat (2) cyc();
    #1;
    chk("prio_mei", trap_cause, 32'h8000_000B);
    ext_irq = 1'b0;
    repeat (3) cyc();
    #1;
    chk("prio_msi", trap_cause, 32'h8000_0003);
    csr_wr(A_MIP, OP_CLEAR, 32'h0000_0008);
    repeat (2) cyc();
    #1;
    chk("prio_local", trap_cause, 32'h8000_0011);
    local_irq = 4'b0000; interrupts_enabled = 1'b0;
    csr_wr(A_MIE, OP_WRITE, 32'h0);

    // exceptions with interrupts globally disabled
    exc = 6'b010001;
    #1;
    chk("exc_pending", trap_pending, 1'b1);
    cyc();
    exc = 6'b000000;
    #1;
    chk("exc_illegal_cause", trap_cause, 32'h0000_0002);

    // randomized run against the model
    for (int k = 0; k < 400; k++) begin
      ext_irq = 1'($urandom_range(0, 1));
      local_irq = 4'($urandom);
      interrupts_enabled = ($urandom_range(0, 3) != 0);
      exc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'b000000;
      csr_addr = ADDRS[$urandom_range(0, 6)];
      csr_write = ($urandom_range(0, 3) == 0);
      csr_op = 2'($urandom);
      if (csr_addr == A_THI || csr_addr == A_CHI) csr_wr_data = $urandom_range(0, 1);
      else if (csr_addr == A_TLO || csr_addr == A_CLO) csr_wr_data = $urandom_range(0, 600);
      else csr_wr_data = $urandom;
      cyc();
    end
    csr_write = 1'b0; csr_op = OP_NONE; exc = 6'h0; ext_irq = 1'b0;
    local_irq = 4'h0; interrupts_enabled = 1'b0; csr_addr = A_TLO;

    // asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mtime", csr_rd_data, 32'h0);
    chk("async_cause", trap_cause, HW_ERR);
    chk("async_pending", trap_pending, 1'b0);
    csr_addr = A_CHI;
    #1;
    chk("async_cmp_hi", csr_rd_data, 32'hFFFF_FFFF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    csr_addr = A_TLO;
    repeat (3) cyc();

    // PRESCALE=3 instance: wrap into the high half and prescaler restart
    csr_write3 = 1'b1; csr_op3 = OP_WRITE; csr_addr3 = A_TLO; csr_wr_data3 = 32'hFFFF_FFFF;
    @(negedge clk);
    csr_write3 = 1'b0; csr_op3 = OP_NONE;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("p3_hold", csr_rd_data3, 32'hFFFF_FFFF);
      @(negedge clk);
    end
    #1;
    chk("p3_wrap_lo", csr_rd_data3, 32'h0);
    csr_addr3 = A_THI;
    #1;
    chk("p3_wrap_hi", csr_rd_data3, 32'h1);
    csr_addr3 = A_TLO;
    @(negedge clk);
    csr_write3 = 1'b1; csr_op3 = OP_WRITE; csr_wr_data3 = 32'd100;
    @(negedge clk);
    csr_write3 = 1'b0; csr_op3 = OP_NONE;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("p3_restart_hold", csr_rd_data3, 32'd100);
      @(negedge clk);
    end
    #1;
    chk("p3_restart_step", csr_rd_data3, 32'd101);
    chk("p3_quiet_pending", trap_pending3, 1'b0);
    chk("p3_quiet_cause", trap_cause3, HW_ERR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
